// File: rtl/spi_slave_12b.sv
// spi_slave_12b: SPI mode-0 (CPOL=0, CPHA=0) responder.
// All SPI pins are oversampled in the clk domain. Words are shifted MSB
// first in both directions. Received words are presented on rx_data with a
// one-cycle rx_valid pulse. Transmit words are written into tx_buf while the
// block is idle and are re-sent on every frame until a new word is loaded.
// A frame that ends early (cs_n rises before WIDTH bits) pulses frame_err.

module spi_slave_12b #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  // Bit counter is wide enough to hold WIDTH itself (saturation value).
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // FSM encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Synchronizer chains. Index 0 is the stage nearest the pin.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_chain;
  // Fills with ones after reset; its last bit says the chains above now
  // carry real pin values instead of their reset values.
  logic [SYNC_STAGES-1:0] prime_sr;

  logic sclk_s;
  logic cs_s;
  logic mosi_sync;

  // Delayed copies used for edge detection, plus registered edge flags.
  logic sclk_dly;
  logic cs_dly;
  logic mosi_dly;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  // Set once cs_n has been observed high after reset. A frame may only
  // start from a fall seen while armed, so a cs_n held low through reset
  // must first return high before the next frame can begin.
  logic armed;

  // Datapath and control registers.
  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  // Host side may write tx_buf only while no frame is in progress.
  assign tx_ready = (state == IDLE);

  // Synchronize the SPI pins; cs_n resets to its inactive (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= '0;
      cs_sync    <= '1;
      mosi_chain <= '0;
      prime_sr   <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
      prime_sr   <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge detection against one extra delayed flop. mosi is delayed by the
  // same amount so the data bit lines up with the registered sclk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b1;
      mosi_dly  <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_dly  <= sclk_s;
      cs_dly    <= cs_s;
      mosi_dly  <= mosi_sync;
      sclk_rise <= sclk_s & ~sclk_dly;
      sclk_fall <= ~sclk_s & sclk_dly;
      cs_rise   <= cs_s & ~cs_dly;
      cs_fall   <= ~cs_s & cs_dly;
      if (prime_sr[SYNC_STAGES-1] && cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM: loads, shifts in/out on sclk edges, cs_n edges take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_buf    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (tx_load) begin
            tx_buf <= tx_data;
          end
          // The current tx_buf is committed at frame start; a load in the
          // same cycle only affects the following frame.
          if (cs_fall && armed) begin
            tx_sr   <= tx_buf;
            rx_sr   <= '0;
            bit_cnt <= '0;
            miso    <= tx_buf[WIDTH-1];
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // Early end of frame: drop the partial word, keep rx_data.
            frame_err <= 1'b1;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            miso      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise && (bit_cnt < CNT_MAX)) begin
            rx_sr   <= {rx_sr[WIDTH-2:0], mosi_dly};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_LAST) begin
              rx_data  <= {rx_sr[WIDTH-2:0], mosi_dly};
              rx_valid <= 1'b1;
              miso     <= 1'b0;
              state    <= DONE;
            end
          end else if (sclk_fall && (bit_cnt < CNT_MAX)) begin
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
            miso  <= tx_sr[WIDTH-2];
          end
        end

        DONE: begin
          // Extra sclk edges are ignored until the master releases cs_n.
          miso <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          miso  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_12b.sv
// Testbench for spi_slave_12b: table-driven frames, hand-written corner
// sequences (blocked load, reset mid-frame) and randomized frames checked
// against a word-level model of the link.

module tb_spi_slave_12b;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int rxv_cnt     = 0;
  int ferr_cnt    = 0;

  // Word-level model state: word that will be sent, last received word.
  logic [W-1:0] tx_m;
  logic [W-1:0] rx_m;

  typedef struct {
    bit          do_load;
    logic [W-1:0] tx;
    int          n;
    logic [31:0] bits;
    int          exp_rxv;
    int          exp_err;
    logic [W-1:0] exp_rx;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t tbl [4];

  spi_slave_12b #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters for the single-cycle strobes.
  always @(posedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] d);
    tx_data = d;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    clks(10);
  endtask

  // One sclk period (16 clk): present mosi, sample miso just before the rise.
  task automatic bit_cycle(input logic b, output logic m);
    mosi = b;
    clks(8);
    m    = miso;
    sclk = 1'b1;
    clks(8);
    sclk = 1'b0;
  endtask

  task automatic cs_high();
    clks(8);
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(12);
  endtask

  // Full frame of n sclk pulses; bits[n-1] is sent first.
  task automatic run_frame(input logic [31:0] bits, input int n,
                           output logic [31:0] mv, output int drxv, output int derr);
    int   r0;
    int   e0;
    logic m;
    r0 = rxv_cnt;
    e0 = ferr_cnt;
    mv = '0;
    cs_low();
    for (int i = 0; i < n; i++) begin
      bit_cycle(bits[n-1-i], m);
      mv = {mv[30:0], m};
    end
    cs_high();
    drxv = rxv_cnt - r0;
    derr = ferr_cnt - e0;
  endtask

  initial begin
    logic [31:0] mv;
    logic [31:0] em;
    logic [31:0] bits;
    logic [W-1:0] w;
    logic        m;
    int          drxv;
    int          derr;
    int          n;
    int          r0;
    int          e0;

    tbl[0] = '{1'b1, 12'h3F1, 12, 32'hA5C,  1, 0, 12'hA5C, 32'h3F1};
    tbl[1] = '{1'b0, 12'h000, 5,  32'h15,   0, 1, 12'hA5C, 32'h07};
    tbl[2] = '{1'b0, 12'h000, 12, 32'h001,  1, 0, 12'h001, 32'h3F1};
    tbl[3] = '{1'b1, 12'h8C3, 14, 32'h3FFE, 1, 0, 12'hFFF, 32'h230C};

    rst     = 1'b1;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    clks(3);

    // Reset values
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    clks(20);
    check("post_rst_rxv_pulses", rxv_cnt, 0);
    check("post_rst_err_pulses", ferr_cnt, 0);
    tx_m = '0;
    rx_m = '0;

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].do_load) begin
        load(tbl[i].tx);
        tx_m = tbl[i].tx;
      end
      run_frame(tbl[i].bits, tbl[i].n, mv, drxv, derr);
      check($sformatf("tbl%0d_rx_valid_pulses", i), drxv, tbl[i].exp_rxv);
      check($sformatf("tbl%0d_frame_err_pulses", i), derr, tbl[i].exp_err);
      check($sformatf("tbl%0d_rx_data", i), rx_data, tbl[i].exp_rx);
      check($sformatf("tbl%0d_miso_seq", i), mv, tbl[i].exp_miso);
      check($sformatf("tbl%0d_tx_ready_idle", i), tx_ready, 1);
      rx_m = tbl[i].exp_rx;
    end

    // Load blocked mid-frame
    load(12'h3F1);
    tx_m = 12'h3F1;
    bits = 32'h6B2;
    r0   = rxv_cnt;
    e0   = ferr_cnt;
    mv   = '0;
    cs_low();
    for (int i = 0; i < 3; i++) begin
      bit_cycle(bits[W-1-i], m);
      mv = {mv[30:0], m};
    end
    check("blk_tx_ready_in_shift", tx_ready, 0);
    load(12'h555);
    for (int i = 3; i < W; i++) begin
      bit_cycle(bits[W-1-i], m);
      mv = {mv[30:0], m};
    end
    cs_high();
    check("blk_rx_data", rx_data, 12'h6B2);
    check("blk_rxv_pulses", rxv_cnt - r0, 1);
    check("blk_miso_seq", mv, 32'h3F1);
    run_frame(32'h123, W, mv, drxv, derr);
    check("blk_next_miso_seq", mv, 32'h3F1);
    check("blk_next_rx_data", rx_data, 12'h123);

    // Reset mid-frame with cs_n held low
    load(12'hABC);
    cs_low();
    for (int i = 0; i < 6; i++) bit_cycle(1'b1, m);
    rst = 1'b1;
    clks(3);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    rst  = 1'b0;
    tx_m = '0;
    rx_m = '0;
    r0   = rxv_cnt;
    e0   = ferr_cnt;
    mv   = '0;
    for (int i = 0; i < W; i++) begin
      bit_cycle(1'b1, m);
      mv = {mv[30:0], m};
    end
    cs_high();
    check("after_rst_miso_seq", mv, 0);
    check("after_rst_rxv_pulses", rxv_cnt - r0, 0);
    check("after_rst_err_pulses", ferr_cnt - e0, 0);
    run_frame(32'h9E7, W, mv, drxv, derr);
    check("after_rst_frame_rx", rx_data, 12'h9E7);
    check("after_rst_frame_miso", mv, 0);
    rx_m = 12'h9E7;

    // Randomized frames against the word-level model
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = W'($urandom);
        load(w);
        tx_m = w;
      end
      n    = int'($urandom_range(0, W + 3));
      bits = $urandom;
      em   = '0;
      for (int i = 0; i < n; i++) begin
        em = {em[30:0], (i < W) ? tx_m[W-1-i] : 1'b0};
      end
      if (n >= W) begin
        w = '0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], bits[n-1-i]};
        rx_m = w;
      end
      run_frame(bits, n, mv, drxv, derr);
      check($sformatf("rnd%0d_n%0d_rxv", k, n), drxv, (n >= W) ? 1 : 0);
      check($sformatf("rnd%0d_n%0d_err", k, n), derr, (n < W) ? 1 : 0);
      check($sformatf("rnd%0d_n%0d_rx_data", k, n), rx_data, rx_m);
      check($sformatf("rnd%0d_n%0d_miso", k, n), mv, em);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
